dfr_mem_arbiter: RTL and testbench

Single-port RAM arbiter for the DFR core memories. It shares one `ram` instance (input, reservoir history, output weight or DFR output memory) between the AXI config-register host port and up to three datapath requesters: reservoir history writer, matrix multiplier reader and DFR output writer. Host access therefore works while the core is busy instead of being muxed out by `busy`. Arbitration is round-robin with an optional burst lock, and read data is returned with a per-requester valid tag.

---
 rtl/dfr_mem_arbiter.sv | 114 +++++++++++
 tb/tb_dfr_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dfr_mem_arbiter.sv
// rtl/dfr_mem_arbiter.sv - round-robin single-port RAM arbiter with burst lock and tagged read return
// Optional host priority: define DFR_ARB_HOST_PRIORITY_EN to let requester 0 win every unlocked arbitration.
module dfr_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ-1:0]               wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic                             mem_wen,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [DATA_WIDTH-1:0]            mem_dout
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic ST_ARB    = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic               state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [NUM_REQ-1:0] rd_tag;

  logic               hit;
  logic               hold;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   cidx;
  logic               ptr_upd;

  // Pick the winner: the lock owner while it keeps req and lock, otherwise scan from ptr.
  // A dropped lock falls through to the scan in the same cycle; ptr already sits at owner+1.
  always_comb begin
    hit     = 1'b0;
    gidx    = '0;
    cidx    = '0;
    ptr_upd = 1'b1;
    hold    = (state == ST_LOCKED) && req[owner] && lock[owner];
    if (rst) begin
      hit = 1'b0;
    end else if (hold) begin
      hit  = 1'b1;
      gidx = owner;
`ifdef DFR_ARB_HOST_PRIORITY_EN
    end else if (req[0]) begin
      hit     = 1'b1;
      gidx    = '0;
      ptr_upd = 1'b0;
`endif
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cidx = PTR_W'((int'(ptr) + k) % NUM_REQ);
        if (!hit && req[cidx]) begin
          hit  = 1'b1;
          gidx = cidx;
        end
      end
    end
    ptr_nxt = PTR_W'((int'(gidx) + 1) % NUM_REQ);
  end

  // One-hot grant and RAM port steering; an idle cycle drives zeros.
  always_comb begin
    gnt      = '0;
    mem_addr = '0;
    mem_din  = '0;
    mem_wen  = 1'b0;
    if (hit) begin
      gnt[gidx] = 1'b1;
      mem_addr  = addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
      mem_din   = wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
      mem_wen   = wen[gidx];
    end
  end

  // Arbitration state, pointer and read tag; the tag lines up with the RAM's one-cycle read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_ARB;
      ptr    <= '0;
      owner  <= '0;
      rd_tag <= '0;
    end else begin
      rd_tag <= (hit && !wen[gidx]) ? gnt : '0;
      if (hit) begin
        if (ptr_upd) begin
          ptr <= ptr_nxt;
        end
        if (lock[gidx]) begin
          state <= ST_LOCKED;
          owner <= gidx;
        end else begin
          state <= ST_ARB;
        end
      end else begin
        state <= ST_ARB;
      end
    end
  end

  assign rvalid = rd_tag;
  assign rdata  = mem_dout;

endmodule

// File: tb/tb_dfr_mem_arbiter.sv
// tb/tb_dfr_mem_arbiter.sv - directed self-checking bench for dfr_mem_arbiter with a behavioural RAM
module tb_dfr_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = '0;
  logic [3:0]   lock = '0;
  logic [3:0]   wen = '0;
  logic [55:0]  addr = '0;
  logic [127:0] wdata = '0;
  logic [3:0]   gnt;
  logic [3:0]   rvalid;
  logic [31:0]  rdata;
  logic [13:0]  mem_addr;
  logic         mem_wen;
  logic [31:0]  mem_din;
  logic [31:0]  mem_dout = '0;

  logic [31:0]  ram [0:16383];

  int checks   = 0;
  int failures = 0;

  dfr_mem_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(14), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wen(wen), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int i, input logic [13:0] a, input logic [31:0] d);
    addr[i*14 +: 14]  = a;
    wdata[i*32 +: 32] = d;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [3:0] w);
    @(negedge clk);
    req  = r;
    lock = l;
    wen  = w;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = '0;
    ram[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) ram[10+i] = 32'hA000_0000 + i;
    for (int i = 0; i < 4; i++) set_port(i, 14'(10 + i), 32'h0);

    // Reset state with every requester asking to write.
    drive(4'b1111, 4'b0000, 4'b1111);
    check("rst_rvalid", {28'h0, rvalid}, 32'h0);
    check("rst_gnt", {28'h0, gnt}, 32'h0);
    check("rst_mem_wen", {31'h0, mem_wen}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    wen = '0;

`ifndef DFR_ARB_HOST_PRIORITY_EN
    // Single requester read of preloaded address 5.
    set_port(2, 14'd5, 32'h0);
    drive(4'b0100, 4'b0000, 4'b0000);
    check("single_gnt", {28'h0, gnt}, 32'h4);
    check("single_mem_addr", {18'h0, mem_addr}, 32'd5);
    drive(4'b0000, 4'b0000, 4'b0000);
    check("single_rvalid", {28'h0, rvalid}, 32'h4);
    check("single_rdata", rdata, 32'hDEAD_BEEF);
    check("idle_gnt", {28'h0, gnt}, 32'h0);
    check("idle_mem_addr", {18'h0, mem_addr}, 32'h0);

    // Requester 3 alone wraps ptr back to 0.
    set_port(2, 14'd12, 32'h0);
    drive(4'b1000, 4'b0000, 4'b0000);
    check("wrap_gnt", {28'h0, gnt}, 32'h8);

    // All four reading continuously: grants 0,1,2,3,0 with rvalid one behind.
    drive(4'b1111, 4'b0000, 4'b0000);
    check("rr0_gnt", {28'h0, gnt}, 32'h1);
    check("rr0_rvalid", {28'h0, rvalid}, 32'h8);
    check("rr0_rdata", rdata, 32'hA000_0003);
    drive(4'b1111, 4'b0000, 4'b0000);
    check("rr1_gnt", {28'h0, gnt}, 32'h2);
    check("rr1_rvalid", {28'h0, rvalid}, 32'h1);
    check("rr1_rdata", rdata, 32'hA000_0000);
    drive(4'b1111, 4'b0000, 4'b0000);
    check("rr2_gnt", {28'h0, gnt}, 32'h4);
    check("rr2_rvalid", {28'h0, rvalid}, 32'h2);
    check("rr2_rdata", rdata, 32'hA000_0001);
    drive(4'b1111, 4'b0000, 4'b0000);
    check("rr3_gnt", {28'h0, gnt}, 32'h8);
    check("rr3_rvalid", {28'h0, rvalid}, 32'h4);
    check("rr3_rdata", rdata, 32'hA000_0002);
    drive(4'b1111, 4'b0000, 4'b0000);
    check("rr4_gnt", {28'h0, gnt}, 32'h1);
    check("rr4_rvalid", {28'h0, rvalid}, 32'h8);
    drive(4'b0010, 4'b0000, 4'b0000);
    check("rr5_gnt", {28'h0, gnt}, 32'h2);
    check("rr5_rvalid", {28'h0, rvalid}, 32'h1);
    check("rr5_rdata", rdata, 32'hA000_0000);

    // Lock hold: requester 2 keeps the port for 4 cycles, then 3, then 1.
    for (int c = 0; c < 4; c++) begin
      drive(4'b1110, 4'b0100, 4'b0000);
      check($sformatf("lock%0d_gnt", c), {28'h0, gnt}, 32'h4);
    end
    check("lock_rvalid", {28'h0, rvalid}, 32'h4);
    check("lock_rdata", rdata, 32'hA000_0002);
    drive(4'b1010, 4'b0000, 4'b0000);
    check("unlock_gnt", {28'h0, gnt}, 32'h8);
    drive(4'b0010, 4'b0000, 4'b0000);
    check("after_unlock_gnt", {28'h0, gnt}, 32'h2);

    // Write-then-read through different requesters.
    set_port(1, 14'd100, 32'h0000_1234);
    set_port(2, 14'd100, 32'h0);
    drive(4'b0010, 4'b0000, 4'b0010);
    check("wr_gnt", {28'h0, gnt}, 32'h2);
    check("wr_mem_wen", {31'h0, mem_wen}, 32'h1);
    check("wr_mem_din", mem_din, 32'h0000_1234);
    check("wr_mem_addr", {18'h0, mem_addr}, 32'd100);
    drive(4'b0100, 4'b0000, 4'b0000);
    check("rd_gnt", {28'h0, gnt}, 32'h4);
    check("wr_no_rvalid", {28'h0, rvalid}, 32'h0);
    drive(4'b0000, 4'b0000, 4'b0000);
    check("rd_rvalid", {28'h0, rvalid}, 32'h4);
    check("rd_rdata", rdata, 32'h0000_1234);

    // Reset in the cycle after a granted read: rvalid clears at once, ptr returns to 0.
    set_port(0, 14'd10, 32'h0);
    set_port(3, 14'd13, 32'h0);
    drive(4'b0001, 4'b0000, 4'b0000);
    check("pre_rst_gnt", {28'h0, gnt}, 32'h1);
    drive(4'b0000, 4'b0000, 4'b0000);
    check("pre_rst_rvalid", {28'h0, rvalid}, 32'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_rvalid", {28'h0, rvalid}, 32'h0);
    drive(4'b1001, 4'b0000, 4'b0000);
    check("mid_rst_gnt", {28'h0, gnt}, 32'h0);
    rst = 1'b0;
    #1;
    check("post_rst_gnt", {28'h0, gnt}, 32'h1);
    drive(4'b1000, 4'b0000, 4'b0000);
    check("post_rst_gnt2", {28'h0, gnt}, 32'h8);
    check("post_rst_rvalid", {28'h0, rvalid}, 32'h1);
    check("post_rst_rdata", rdata, 32'hA000_0000);
`else
    // Host priority: requester 0 wins every cycle and leaves ptr alone.
    for (int c = 0; c < 3; c++) begin
      drive(4'b0111, 4'b0000, 4'b0000);
      check($sformatf("host%0d_gnt", c), {28'h0, gnt}, 32'h1);
    end
    check("host_rvalid", {28'h0, rvalid}, 32'h1);
    drive(4'b0110, 4'b0000, 4'b0000);
    check("host_drop_gnt", {28'h0, gnt}, 32'h2);
    drive(4'b0110, 4'b0000, 4'b0000);
    check("host_drop_gnt2", {28'h0, gnt}, 32'h4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
